// File: rtl/cmp_pkg.sv
// cmp_pkg
// Shared types and helpers for the pipelined comparator.
//   cmp_result_t      : one comparison outcome (equal / greater / less)
//   CMP_DEF_WIDTH     : default operand width
//   CMP_DEF_CNT_WIDTH : default result counter width
//   cmp_sat_inc       : saturating increment for counters up to 32 bits wide
package cmp_pkg;

    typedef enum logic [1:0] {
        CMP_EQ = 2'd0,
        CMP_GT = 2'd1,
        CMP_LT = 2'd2
    } cmp_result_t;

    localparam int CMP_DEF_WIDTH     = 16;
    localparam int CMP_DEF_CNT_WIDTH = 8;

    // Counters are carried through this helper zero-extended to 32 bits.
    // The caller truncates the result back to its own width. The ceiling is
    // 2^width-1, so a counter parks at all-ones instead of wrapping.
    function automatic logic [31:0] cmp_sat_inc(input logic [31:0] value,
                                                 input int          width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (value >= max_val) ? max_val : value + 32'd1;
    endfunction

endpackage

// File: rtl/cmp_core.sv
// cmp_core
// Purely combinational magnitude comparator.
//   WIDTH  : operand width
//   SIGNED : 0 compares as unsigned, 1 compares as two's complement
//   a, b   : operands
//   result : CMP_EQ / CMP_GT / CMP_LT for a relative to b
module cmp_core
    import cmp_pkg::*;
#(
    parameter int WIDTH  = CMP_DEF_WIDTH,
    parameter int SIGNED = 0
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output cmp_result_t      result
);

    logic a_greater;

    // The signedness only changes how the ordering is evaluated.
    // Equality is the same bit pattern check in both modes.
    if (SIGNED != 0) begin : g_signed
        assign a_greater = $signed(a) > $signed(b);
    end else begin : g_unsigned
        assign a_greater = a > b;
    end

    always_comb begin
        result = CMP_LT;
        if (a == b) begin
            result = CMP_EQ;
        end else if (a_greater) begin
            result = CMP_GT;
        end
    end

endmodule

// File: rtl/pipelined_comparator.sv
// pipelined_comparator
// Streaming magnitude comparator. It has a single registered result stage,
// ready/valid flow control and saturating per-class statistics.
// Optional feature macro: CMP_MINMAX_EN enables running min/max of operand a.
// When the macro is undefined, max_a and min_a read as 0.
// Ports:
//   clk, n_rst           : clock, asynchronous active-low reset
//   clear                : synchronous clear of counters, min/max, stats_valid
//   a, b, in_valid       : operand pair and its valid
//   in_ready             : pair can be accepted this cycle
//   out_valid, out_ready : held result handshake
//   gt, lt, eq           : one-hot flags of the held pair
//   gt/lt/eq_count       : saturating per-class counters
//   max_a, min_a         : running max/min of accepted a
//   stats_valid          : at least one pair accepted since reset/clear
module pipelined_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH     = CMP_DEF_WIDTH,
    parameter int SIGNED    = 0,
    parameter int CNT_WIDTH = CMP_DEF_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 clear,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 gt,
    output logic                 lt,
    output logic                 eq,
    output logic [CNT_WIDTH-1:0] gt_count,
    output logic [CNT_WIDTH-1:0] lt_count,
    output logic [CNT_WIDTH-1:0] eq_count,
    output logic [WIDTH-1:0]     max_a,
    output logic [WIDTH-1:0]     min_a,
    output logic                 stats_valid
);

    cmp_result_t ab_result;
    logic        transfer;

    cmp_core #(
        .WIDTH  (WIDTH),
        .SIGNED (SIGNED)
    ) u_cmp_ab (
        .a      (a),
        .b      (b),
        .result (ab_result)
    );

    // The output register is a one-entry buffer. It can take a new pair
    // whenever it is empty or is being drained in this same cycle.
    assign in_ready = !out_valid || out_ready;
    assign transfer = in_valid && in_ready;

    // Result stage. Flags are kept as three separate bits instead of a
    // cmp_result_t, because reset needs all three to be 0.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            out_valid <= 1'b0;
            gt        <= 1'b0;
            lt        <= 1'b0;
            eq        <= 1'b0;
        end else if (transfer) begin
            out_valid <= 1'b1;
            gt        <= (ab_result == CMP_GT);
            lt        <= (ab_result == CMP_LT);
            eq        <= (ab_result == CMP_EQ);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Statistics update at transfer time.
    // A clear in the same cycle as a transfer restarts counting with that
    // pair, so its class counter starts at 1 instead of 0.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            gt_count    <= '0;
            lt_count    <= '0;
            eq_count    <= '0;
            stats_valid <= 1'b0;
        end else if (clear) begin
            gt_count    <= (transfer && ab_result == CMP_GT) ? CNT_WIDTH'(1) : '0;
            lt_count    <= (transfer && ab_result == CMP_LT) ? CNT_WIDTH'(1) : '0;
            eq_count    <= (transfer && ab_result == CMP_EQ) ? CNT_WIDTH'(1) : '0;
            stats_valid <= transfer;
        end else if (transfer) begin
            stats_valid <= 1'b1;
            case (ab_result)
                CMP_GT:  gt_count <= CNT_WIDTH'(cmp_sat_inc(32'(gt_count), CNT_WIDTH));
                CMP_LT:  lt_count <= CNT_WIDTH'(cmp_sat_inc(32'(lt_count), CNT_WIDTH));
                default: eq_count <= CNT_WIDTH'(cmp_sat_inc(32'(eq_count), CNT_WIDTH));
            endcase
        end
    end

`ifdef CMP_MINMAX_EN
    logic [WIDTH-1:0] max_q;
    logic [WIDTH-1:0] min_q;
    cmp_result_t      a_vs_max;
    cmp_result_t      a_vs_min;

    cmp_core #(
        .WIDTH  (WIDTH),
        .SIGNED (SIGNED)
    ) u_cmp_max (
        .a      (a),
        .b      (max_q),
        .result (a_vs_max)
    );

    cmp_core #(
        .WIDTH  (WIDTH),
        .SIGNED (SIGNED)
    ) u_cmp_min (
        .a      (a),
        .b      (min_q),
        .result (a_vs_min)
    );

    // The first pair after reset or clear seeds both extremes.
    // stats_valid low means no pair has been seen yet.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            max_q <= '0;
            min_q <= '0;
        end else if (transfer) begin
            if (clear || !stats_valid) begin
                max_q <= a;
                min_q <= a;
            end else begin
                if (a_vs_max == CMP_GT) begin
                    max_q <= a;
                end
                if (a_vs_min == CMP_LT) begin
                    min_q <= a;
                end
            end
        end else if (clear) begin
            max_q <= '0;
            min_q <= '0;
        end
    end

    assign max_a = max_q;
    assign min_a = min_q;
`else
    assign max_a = '0;
    assign min_a = '0;
`endif

endmodule

// File: tb/tb_pipelined_comparator.sv
// tb_pipelined_comparator
// Self-checking bench. It runs two comparators side by side on the same
// stimulus:
//   - one unsigned instance with 4-bit counters;
//   - one signed instance with 2-bit counters.
// Both are checked against a behavioural model. If CMP_MINMAX_EN is defined
// for the build, the min/max outputs are checked as well.
module tb_pipelined_comparator;

    localparam int W    = 8;
    localparam int CW_U = 4;
    localparam int CW_S = 2;
`ifdef CMP_MINMAX_EN
    localparam bit MINMAX = 1'b1;
`else
    localparam bit MINMAX = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         n_rst;
    logic         clear;
    logic         in_valid;
    logic         out_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;

    logic            in_ready_u, out_valid_u, gt_u, lt_u, eq_u, sv_u;
    logic [CW_U-1:0] gtc_u, ltc_u, eqc_u;
    logic [W-1:0]    max_u, min_u;
    logic            in_ready_s, out_valid_s, gt_s, lt_s, eq_s, sv_s;
    logic [CW_S-1:0] gtc_s, ltc_s, eqc_s;
    logic [W-1:0]    max_s, min_s;

    pipelined_comparator #(.WIDTH(W), .SIGNED(0), .CNT_WIDTH(CW_U)) dut_u (
        .clk(clk), .n_rst(n_rst), .clear(clear), .a(a), .b(b),
        .in_valid(in_valid), .in_ready(in_ready_u), .out_valid(out_valid_u),
        .out_ready(out_ready), .gt(gt_u), .lt(lt_u), .eq(eq_u),
        .gt_count(gtc_u), .lt_count(ltc_u), .eq_count(eqc_u),
        .max_a(max_u), .min_a(min_u), .stats_valid(sv_u)
    );

    pipelined_comparator #(.WIDTH(W), .SIGNED(1), .CNT_WIDTH(CW_S)) dut_s (
        .clk(clk), .n_rst(n_rst), .clear(clear), .a(a), .b(b),
        .in_valid(in_valid), .in_ready(in_ready_s), .out_valid(out_valid_s),
        .out_ready(out_ready), .gt(gt_s), .lt(lt_s), .eq(eq_s),
        .gt_count(gtc_s), .lt_count(ltc_s), .eq_count(eqc_s),
        .max_a(max_s), .min_a(min_s), .stats_valid(sv_s)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state. Index 0 is the unsigned instance, 1 the signed.
    // Class codes: 0 none, 1 gt, 2 lt, 3 eq. Counter index = class-1.
    bit     m_valid;
    int     m_cls[2];
    int     m_cnt[2][3];
    longint m_max[2];
    longint m_min[2];
    bit     m_sv[2];

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        int           cls_u;
        int           cls_s;
    } vec_t;

    function automatic longint val(logic [W-1:0] x, int d);
        if (d != 0) return longint'($signed(x));
        return longint'(x);
    endfunction

    function automatic int classify(logic [W-1:0] x, logic [W-1:0] y, int d);
        longint xv = val(x, d);
        longint yv = val(y, d);
        if (xv == yv) return 3;
        if (xv > yv) return 1;
        return 2;
    endfunction

    task automatic checkOutput(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        m_valid = 1'b0;
        for (int d = 0; d < 2; d++) begin
            m_cls[d] = 0;
            for (int k = 0; k < 3; k++) m_cnt[d][k] = 0;
            m_max[d] = 0;
            m_min[d] = 0;
            m_sv[d]  = 1'b0;
        end
    endtask

    task automatic modelStep(bit iv, bit ordy, bit clr, logic [W-1:0] av, logic [W-1:0] bv);
        bit     xfer;
        int     cls;
        int     lim;
        longint x;
        xfer = iv && (!m_valid || ordy);
        for (int d = 0; d < 2; d++) begin
            lim = (d == 0) ? (1 << CW_U) - 1 : (1 << CW_S) - 1;
            if (clr) begin
                for (int k = 0; k < 3; k++) m_cnt[d][k] = 0;
                m_sv[d]  = 1'b0;
                m_max[d] = 0;
                m_min[d] = 0;
            end
            if (xfer) begin
                cls = classify(av, bv, d);
                m_cls[d] = cls;
                if (m_cnt[d][cls-1] < lim) m_cnt[d][cls-1]++;
                x = val(av, d);
                if (!m_sv[d]) begin
                    m_max[d] = x;
                    m_min[d] = x;
                end else begin
                    if (x > m_max[d]) m_max[d] = x;
                    if (x < m_min[d]) m_min[d] = x;
                end
                m_sv[d] = 1'b1;
            end
        end
        if (xfer) m_valid = 1'b1;
        else if (ordy) m_valid = 1'b0;
    endtask

    task automatic checkDut(string tag, int d, logic ov, logic g, logic l, logic e,
                            longint gc, longint lc, longint ec,
                            longint mx, longint mn, logic sv);
        checkOutput({tag, "_out_valid"}, longint'(ov), longint'(m_valid));
        checkOutput({tag, "_gt"}, longint'(g), longint'(m_cls[d] == 1));
        checkOutput({tag, "_lt"}, longint'(l), longint'(m_cls[d] == 2));
        checkOutput({tag, "_eq"}, longint'(e), longint'(m_cls[d] == 3));
        checkOutput({tag, "_gt_count"}, gc, longint'(m_cnt[d][0]));
        checkOutput({tag, "_lt_count"}, lc, longint'(m_cnt[d][1]));
        checkOutput({tag, "_eq_count"}, ec, longint'(m_cnt[d][2]));
        checkOutput({tag, "_max_a"}, mx, MINMAX ? m_max[d] : 0);
        checkOutput({tag, "_min_a"}, mn, MINMAX ? m_min[d] : 0);
        checkOutput({tag, "_stats_valid"}, longint'(sv), longint'(m_sv[d]));
    endtask

    task automatic compareState();
        checkDut("u", 0, out_valid_u, gt_u, lt_u, eq_u, longint'(gtc_u), longint'(ltc_u),
                 longint'(eqc_u), val(max_u, 0), val(min_u, 0), sv_u);
        checkDut("s", 1, out_valid_s, gt_s, lt_s, eq_s, longint'(gtc_s), longint'(ltc_s),
                 longint'(eqc_s), val(max_s, 1), val(min_s, 1), sv_s);
    endtask

    // Drive one cycle of inputs and check in_ready before the edge.
    // Then advance the model, cross the edge, and check the registered outputs.
    task automatic applyStimulus(bit iv, logic [W-1:0] av, logic [W-1:0] bv, bit ordy, bit clr);
        in_valid  = iv;
        a         = av;
        b         = bv;
        out_ready = ordy;
        clear     = clr;
        #1;
        checkOutput("u_in_ready", longint'(in_ready_u), longint'(!m_valid || ordy));
        checkOutput("s_in_ready", longint'(in_ready_s), longint'(!m_valid || ordy));
        modelStep(iv, ordy, clr, av, bv);
        @(posedge clk);
        #1;
        compareState();
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{8'd5,   8'd3,   1, 1};
        vecs[1] = '{8'd3,   8'd5,   2, 2};
        vecs[2] = '{8'd7,   8'd7,   3, 3};
        vecs[3] = '{8'h80,  8'h01,  1, 2};
        vecs[4] = '{8'hFF,  8'h00,  1, 2};
        vecs[5] = '{8'h7F,  8'h80,  2, 1};

        n_rst = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        compareState();
        checkOutput("u_in_ready_reset", longint'(in_ready_u), 1);
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk);
        #1;

        // Directed table: one pair per cycle with the consumer always ready.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, vecs[i].va, vecs[i].vb, 1'b1, 1'b0);
            checkOutput($sformatf("tbl%0d_u_gt", i), longint'(gt_u), longint'(vecs[i].cls_u == 1));
            checkOutput($sformatf("tbl%0d_u_lt", i), longint'(lt_u), longint'(vecs[i].cls_u == 2));
            checkOutput($sformatf("tbl%0d_u_eq", i), longint'(eq_u), longint'(vecs[i].cls_u == 3));
            checkOutput($sformatf("tbl%0d_s_gt", i), longint'(gt_s), longint'(vecs[i].cls_s == 1));
            checkOutput($sformatf("tbl%0d_s_lt", i), longint'(lt_s), longint'(vecs[i].cls_s == 2));
            checkOutput($sformatf("tbl%0d_s_eq", i), longint'(eq_s), longint'(vecs[i].cls_s == 3));
            if (i == 2) begin
                checkOutput("first3_gt_count", longint'(gtc_u), 1);
                checkOutput("first3_lt_count", longint'(ltc_u), 1);
                checkOutput("first3_eq_count", longint'(eqc_u), 1);
            end
        end

        // Backpressure: the held result survives while the consumer stalls.
        applyStimulus(1'b0, 8'd0, 8'd0, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'd9, 8'd2, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'd1, 8'd1, 1'b0, 1'b0);
        checkOutput("stall_in_ready", longint'(in_ready_u), 0);
        checkOutput("stall_gt_held", longint'(gt_u), 1);
        applyStimulus(1'b1, 8'd2, 8'd9, 1'b1, 1'b0);
        checkOutput("resume_lt", longint'(lt_u), 1);
        checkOutput("resume_out_valid", longint'(out_valid_u), 1);

        // Saturation of the 2-bit counters after a clear.
        applyStimulus(1'b0, 8'd0, 8'd0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, W'(i), W'(i), 1'b1, 1'b0);
        checkOutput("sat_eq_count_s", longint'(eqc_s), 3);
        checkOutput("sat_eq_count_u", longint'(eqc_u), 5);

        // Clear coinciding with a transfer: that pair restarts the statistics.
        applyStimulus(1'b0, 8'd0, 8'd0, 1'b1, 1'b1);
        applyStimulus(1'b1, 8'd10, 8'd3, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'd4, 8'd4, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'd12, 8'd12, 1'b1, 1'b1);
        checkOutput("clr_xfer_max", val(max_u, 0), MINMAX ? 12 : 0);
        checkOutput("clr_xfer_min", val(min_u, 0), MINMAX ? 12 : 0);
        checkOutput("clr_xfer_eq_count", longint'(eqc_u), 1);
        checkOutput("clr_xfer_gt_count", longint'(gtc_u), 0);
        checkOutput("clr_xfer_stats_valid", longint'(sv_u), 1);

        // Asynchronous reset mid-stream, between clock edges.
        applyStimulus(1'b1, 8'd1, 8'd2, 1'b0, 1'b0);
        #2;
        n_rst = 1'b0;
        #1;
        checkOutput("areset_out_valid", longint'(out_valid_u), 0);
        checkOutput("areset_lt", longint'(lt_u), 0);
        checkOutput("areset_eq_count", longint'(eqc_u), 0);
        checkOutput("areset_stats_valid", longint'(sv_u), 0);
        checkOutput("areset_in_ready", longint'(in_ready_u), 1);
        modelReset();
        compareState();
        @(negedge clk);
        n_rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        compareState();

        // Random traffic with random backpressure and occasional clears.
        for (int i = 0; i < 400; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = W'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ra : W'($urandom);
            applyStimulus($urandom_range(0, 3) != 0, ra, rb,
                          $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
